// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver: latches a display word, then scans
// DIGITS digits round-robin with BCD/hex glyphs and leading-zero blanking.
module seven_segment_scanner #(
    parameter int DIGITS      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic                  LOAD,
    input  logic                  MODE,
    input  logic                  BLANK_LEADING,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME_DONE
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         prescaler_q, prescaler_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                  frame_q, frame_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  terminal_s;
    logic [3:0]            nibble_s;
    logic                  zero_run_s;
    logic                  blank_s;

    // Glyph lookup; A-F fall back to a dash outside hex mode.
    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = hex ? 7'b1110111 : 7'b0000001;
            4'hB:    g = hex ? 7'b0011111 : 7'b0000001;
            4'hC:    g = hex ? 7'b1001110 : 7'b0000001;
            4'hD:    g = hex ? 7'b0111101 : 7'b0000001;
            4'hE:    g = hex ? 7'b1001111 : 7'b0000001;
            4'hF:    g = hex ? 7'b1000111 : 7'b0000001;
            default: g = 7'b0000001;
        endcase
        return g;
    endfunction

    assign terminal_s = (prescaler_q == PW'(REFRESH_DIV - 1));

    // State register: prescaler, digit index, shadow word and all outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prescaler_q <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            frame_q     <= 1'b0;
            seg_q       <= 7'b0000000;
            an_q        <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            frame_q     <= frame_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    // Next-state: dwell counter, round-robin digit advance, shadow capture.
    always_comb begin
        prescaler_d = prescaler_q + PW'(1);
        idx_d       = idx_q;
        frame_d     = 1'b0;
        if (terminal_s) begin
            prescaler_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d   = '0;
                frame_d = 1'b1;
            end else begin
                idx_d   = idx_q + IW'(1);
            end
        end else begin
            idx_d = idx_q;
        end
        if (LOAD) begin
            shadow_d = IN;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Output decode; a digit blanks only when it and every higher nibble are zero.
    always_comb begin
        nibble_s   = shadow_q[4*int'(idx_q) +: 4];
        zero_run_s = 1'b1;
        blank_s    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s && (shadow_q[4*i +: 4] == 4'h0);
            blank_s    = ((i == int'(idx_q)) && (i != 0)) ? zero_run_s : blank_s;
        end
        if (BLANK_LEADING && blank_s) begin
            seg_d = 7'b0000000;
        end else begin
            seg_d = glyph(nibble_s, MODE);
        end
        an_d        = '0;
        an_d[idx_q] = 1'b1;
    end

    generate
        if (DATA_WIDTH > DIGITS * 4) begin : g_unused
            logic unused_upper_s;
            assign unused_upper_s = ^shadow_q[DATA_WIDTH-1:DIGITS*4];
        end
    endgenerate

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign FRAME_DONE = frame_q;

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Parametrised, time-multiplexed multi-digit seven-segment driver for the CPU debug display path.
- Captures a data word into a shadow register on LOAD, then scans DIGITS digits round-robin, one digit enabled at a time.
- Each digit shows one 4-bit nibble, in BCD mode (dash on overflow) or hex mode.
- Adds leading-zero blanking and a frame-complete pulse.

Parameters:
DIGITS, 4, number of multiplexed digits; 1 <= DIGITS, DIGITS*4 <= DATA_WIDTH
DATA_WIDTH, 32, width of IN and of the shadow register
REFRESH_DIV, 50000, CLK cycles each digit stays enabled; >= 1

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
IN  input  DATA_WIDTH  value to display; nibble i drives digit i
LOAD  input  1  capture IN into shadow register this edge
MODE  input  1  0 = BCD/decimal (nibble > 9 shows dash), 1 = hex (A-F glyphs)
BLANK_LEADING  input  1  1 = suppress leading zero digits
SEG  output  7  segments {a,b,c,d,e,f,g}, active-high, registered
AN  output  DIGITS  one-hot digit enable, active-high, registered
FRAME_DONE  output  1  one-cycle pulse when scan wraps from digit DIGITS-1 to 0

Behaviour:
- Reset (RESET low, asynchronous): prescaler=0, digit_idx=0, shadow=0, SEG=0, AN=0, FRAME_DONE=0.
- Shadow register: loads IN on any edge with LOAD=1, otherwise holds. Mid-frame loads take effect immediately; there is no wait for frame end.
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and digit_idx advances. digit_idx wraps DIGITS-1 -> 0.
- FRAME_DONE: registered; 1 for exactly one cycle on the edge where digit_idx wraps to 0. When DIGITS=1 it pulses every REFRESH_DIV cycles.
- Output stage: each edge, SEG and AN are registered from the current digit_idx, shadow, MODE and BLANK_LEADING. This gives a 1-cycle latency from any change in those signals to SEG/AN. AN and SEG always change on the same edge, so there is no ghosting between digits.
- AN = 1 << digit_idx, and exactly one bit is set at all times after the first post-reset edge.
- Nibble for digit i = shadow[4i+3:4i]. Upper shadow bits beyond DIGITS*4 are ignored.
- Glyphs, both modes: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Nibbles A-F in MODE=0: dash 0000001.
- Nibbles A-F in MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading blanking: with BLANK_LEADING=1, digit i (i>0) outputs SEG=0000000 when nibbles i..DIGITS-1 are all zero. AN still asserts for that digit. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Simultaneous LOAD and digit advance: the new shadow and new digit_idx are both visible on SEG one cycle later, consistent with each other.
- REFRESH_DIV=1: digit_idx advances every cycle.
- RESET asserted mid-scan: all state and outputs clear immediately, and the scan restarts from digit 0 with a full REFRESH_DIV dwell.

Test Plan:
- Reset then run, DIGITS=4, REFRESH_DIV=4, shadow=0: during RESET low, SEG=0 and AN=0. After release, AN=0001 and SEG=1111110. AN steps 0010, 0100, 1000 every 4 cycles, then wraps to 0001 with a FRAME_DONE pulse of exactly 1 cycle.
- LOAD IN=0x00001234, MODE=0: digit0 shows 4=0110011, digit1 3=1111001, digit2 2=1101101, digit3 1=0110000. SEG updates 1 cycle after LOAD.
- LOAD IN=0x0000BEEF: with MODE=0, all four digits show dash 0000001. With MODE=1, digits 0..3 show F, E, E, b.
- BLANK_LEADING=1, IN=0x00000050: digits 3 and 2 show SEG=0000000 with AN still cycling, digit1 shows 5, and digit0 shows 0. With IN=0, only digit0 shows 1111110.
- LOAD pulsed while digit2 is active, IN changing 0x1111 -> 0x9999: the next cycle shows 9 on digit2 with no extra delay, and the scan timing is undisturbed.
- RESET pulsed low for 1 cycle mid-dwell on digit3: outputs clear asynchronously, and after release the scan resumes at digit0 with a full 4-cycle dwell.
